// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with an integrated return-address stack.
// One step per clock when step=1. The commands, in priority order, are BSR
// (relative call), RET, LOAD and increment.
// Return addresses live in a circular buffer tracked by a top pointer and a count.
// Optional build macro PCSEQ_STACK_WRAP_EN: a BSR on a full stack overwrites the
// oldest entry instead of dropping the push, and ovf_err is then always 0.
module pc_sequencer #(
    parameter int unsigned PC_W     = 11,
    parameter int unsigned OFS_W    = 10,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned BSR_ADJ  = 2,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       step,
    input  logic                       load,
    input  logic [PC_W-1:0]            d,
    input  logic                       is_bsr,
    input  logic                       is_ret,
    input  logic [OFS_W-1:0]           ofs,
    input  logic                       err_clr,
    output logic [PC_W-1:0]            pc,
    output logic [PC_W-1:0]            stack_top,
    output logic [$clog2(DEPTH):0]     stack_cnt,
    output logic                       stack_full,
    output logic                       stack_empty,
    output logic                       ovf_err,
    output logic                       unf_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [PC_W-1:0]  PC_ONE  = PC_W'(1);
    localparam logic [PC_W-1:0]  PC_ADJ  = PC_W'(BSR_ADJ);
    localparam logic [PC_W-1:0]  PC_RST  = PC_W'(RESET_PC);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  top_q, top_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic [PC_W-1:0]  mem [DEPTH];
    logic             push_en;
    logic [PC_W-1:0]  push_data;
    logic             ovf_set;
    logic             unf_set;

    logic signed [OFS_W-1:0] ofs_s;
    logic [PC_W-1:0]         ofs_ext;
    logic [PC_W-1:0]         pc_inc;

    assign ofs_s   = ofs;
    assign ofs_ext = PC_W'(ofs_s);
    assign pc_inc  = pc_q + PC_ONE;

    // Next-state: command selection, stack pointer/count update and sticky flags
    always_comb begin
        pc_d      = pc_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        push_en   = 1'b0;
        push_data = pc_inc;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;

        if (step) begin
            if (is_bsr) begin
                pc_d = pc_q + ofs_ext - PC_ADJ;
                if (cnt_q != CNT_MAX) begin
                    push_en = 1'b1;
                    ptr_d   = ptr_q + PTR_ONE;
                    cnt_d   = cnt_q + CNT_ONE;
                end else begin
`ifdef PCSEQ_STACK_WRAP_EN
                    // When full, the slot after the top pointer holds the oldest entry.
                    push_en = 1'b1;
                    ptr_d   = ptr_q + PTR_ONE;
`else
                    ovf_set = 1'b1;
`endif
                end
            end else if (is_ret) begin
                if (cnt_q != '0) begin
                    pc_d  = mem[ptr_q];
                    ptr_d = ptr_q - PTR_ONE;
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    pc_d    = pc_inc;
                    unf_set = 1'b1;
                end
            end else if (load) begin
                pc_d = d;
            end else begin
                pc_d = pc_inc;
            end
        end

`ifdef PCSEQ_STACK_WRAP_EN
        ovf_d = ovf_set;
`else
        ovf_d = (ovf_q & ~err_clr) | ovf_set;
`endif
        unf_d = (unf_q & ~err_clr) | unf_set;

        full_d  = (cnt_d == CNT_MAX);
        empty_d = (cnt_d == '0);

        // Forward the value being pushed this edge so stack_top stays registered.
        if (cnt_d == '0)
            top_d = '0;
        else if (push_en)
            top_d = push_data;
        else
            top_d = mem[ptr_d];
    end

    // Control and status registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= PC_RST;
            top_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            top_q   <= top_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Return-address storage; contents are don't-care while the count is zero
    always_ff @(posedge clk) begin
        if (rst_n && push_en)
            mem[ptr_d] <= push_data;
    end

    assign pc          = pc_q;
    assign stack_top   = top_q;
    assign stack_cnt   = cnt_q;
    assign stack_full  = full_q;
    assign stack_empty = empty_q;
    assign ovf_err     = ovf_q;
    assign unf_err     = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: a queue-based reference model feeding a scoreboard.
module tb_pc_sequencer;

    localparam int PC_W  = 11;
    localparam int OFS_W = 10;
    localparam int DEPTH = 4;
    localparam int ADJ   = 2;
    localparam int PC_MOD = 1 << PC_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              step = 1'b0, load = 1'b0, is_bsr = 1'b0, is_ret = 1'b0, err_clr = 1'b0;
    logic [PC_W-1:0]   d = '0;
    logic [OFS_W-1:0]  ofs = '0;
    logic [PC_W-1:0]   pc, stack_top;
    logic [2:0]        stack_cnt;
    logic              stack_full, stack_empty, ovf_err, unf_err;

    pc_sequencer dut (
        .clk(clk), .rst_n(rst_n), .step(step), .load(load), .d(d),
        .is_bsr(is_bsr), .is_ret(is_ret), .ofs(ofs), .err_clr(err_clr),
        .pc(pc), .stack_top(stack_top), .stack_cnt(stack_cnt),
        .stack_full(stack_full), .stack_empty(stack_empty),
        .ovf_err(ovf_err), .unf_err(unf_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pc; int top; int cnt; int full; int empty; int ovf; int unf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // reference model state
    int m_pc = 0;
    int m_stk[$];
    int m_ovf = 0;
    int m_unf = 0;

    function automatic int wrap_pc(int x);
        return ((x % PC_MOD) + PC_MOD) % PC_MOD;
    endfunction

    task automatic chk(string nm, int act, int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic exp_t model_view();
        exp_t e;
        e.pc    = m_pc;
        e.cnt   = m_stk.size();
        e.top   = (m_stk.size() > 0) ? m_stk[$] : 0;
        e.full  = (m_stk.size() == DEPTH) ? 1 : 0;
        e.empty = (m_stk.size() == 0) ? 1 : 0;
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        return e;
    endfunction

    task automatic model_reset();
        m_pc = 0;
        m_stk.delete();
        m_ovf = 0;
        m_unf = 0;
    endtask

    task automatic model_step(bit s, bit ld, int dv, bit b, bit r, int ov, bit clr);
        int new_ovf = 0;
        int new_unf = 0;
        int sofs;
        if (s) begin
            if (b) begin
                sofs = (ov >= (1 << (OFS_W - 1))) ? ov - (1 << OFS_W) : ov;
                if (m_stk.size() < DEPTH) begin
                    m_stk.push_back(wrap_pc(m_pc + 1));
                end else begin
`ifdef PCSEQ_STACK_WRAP_EN
                    void'(m_stk.pop_front());
                    m_stk.push_back(wrap_pc(m_pc + 1));
`else
                    new_ovf = 1;
`endif
                end
                m_pc = wrap_pc(m_pc + sofs - ADJ);
            end else if (r) begin
                if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                else begin
                    m_pc = wrap_pc(m_pc + 1);
                    new_unf = 1;
                end
            end else if (ld) begin
                m_pc = dv;
            end else begin
                m_pc = wrap_pc(m_pc + 1);
            end
        end
        m_ovf = (clr ? 0 : m_ovf) | new_ovf;
        m_unf = (clr ? 0 : m_unf) | new_unf;
    endtask

    task automatic drive(bit s, bit ld, int dv, bit b, bit r, int ov, bit clr);
        step = s; load = ld; d = PC_W'(dv); is_bsr = b; is_ret = r; ofs = OFS_W'(ov); err_clr = clr;
    endtask

    // Issue one command: drive at the falling edge and queue the expected result.
    task automatic do_cycle(bit s, bit ld, int dv, bit b, bit r, int ov, bit clr);
        @(negedge clk);
        drive(s, ld, dv, b, r, ov, clr);
        model_step(s, ld, dv, b, r, ov, clr);
        exp_q.push_back(model_view());
    endtask

    task automatic check_now(string tag);
        exp_t e;
        e = model_view();
        chk({tag, "_pc"},    int'(pc),          e.pc);
        chk({tag, "_top"},   int'(stack_top),   e.top);
        chk({tag, "_cnt"},   int'(stack_cnt),   e.cnt);
        chk({tag, "_empty"}, int'(stack_empty), e.empty);
        chk({tag, "_full"},  int'(stack_full),  e.full);
        chk({tag, "_ovf"},   int'(ovf_err),     e.ovf);
        chk({tag, "_unf"},   int'(unf_err),     e.unf);
    endtask

    // Monitor: after every rising edge compare outputs with the oldest expectation
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_pc",    int'(pc),          e.pc);
            chk("sb_top",   int'(stack_top),   e.top);
            chk("sb_cnt",   int'(stack_cnt),   e.cnt);
            chk("sb_full",  int'(stack_full),  e.full);
            chk("sb_empty", int'(stack_empty), e.empty);
            chk("sb_ovf",   int'(ovf_err),     e.ovf);
            chk("sb_unf",   int'(unf_err),     e.unf);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        #12;
        check_now("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // increment and stall
        repeat (3) do_cycle(1, 0, 0, 0, 0, 0, 0);
        repeat (2) do_cycle(0, 0, 0, 0, 0, 0, 0);

        // reset between edges while a step is pending
        @(negedge clk);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_now("async_rst");
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // BSR then RET
        do_cycle(1, 1, 10, 0, 0, 0, 0);
        do_cycle(1, 0, 0, 1, 0, 20, 0);
        do_cycle(1, 0, 0, 0, 1, 0, 0);

        // negative offset and address wrap
        do_cycle(1, 1, 1, 0, 0, 0, 0);
        do_cycle(1, 0, 0, 1, 0, 10'h3FF, 0);
        do_cycle(1, 0, 0, 0, 1, 0, 0);
        do_cycle(1, 1, 11'h7FF, 0, 0, 0, 0);
        do_cycle(1, 0, 0, 0, 0, 0, 0);

        // priority
        do_cycle(1, 1, 100, 0, 0, 0, 0);
        do_cycle(1, 1, 5, 1, 1, 4, 0);
        do_cycle(1, 0, 0, 0, 1, 0, 0);
        do_cycle(1, 1, 5, 0, 1, 0, 0);
        do_cycle(0, 0, 0, 0, 0, 0, 1);

        // full stack, overflow, drain, underflow, clear
        do_cycle(1, 1, 0, 0, 0, 0, 0);
        repeat (5) do_cycle(1, 0, 0, 1, 0, 2, 0);
        do_cycle(1, 1, 300, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) do_cycle(1, 0, 0, 0, 1, 0, 0);
        do_cycle(1, 0, 0, 0, 1, 0, 1);
        do_cycle(1, 0, 0, 0, 0, 0, 1);

        // distinct return addresses to check stack ordering
        for (int i = 0; i < 5; i++) do_cycle(1, 0, 0, 1, 0, 7 + i, 0);
        for (int i = 0; i < 5; i++) do_cycle(1, 0, 0, 0, 1, 0, 0);
        do_cycle(0, 0, 0, 0, 0, 0, 1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            do_cycle($urandom_range(0, 9) != 0,
                     $urandom_range(0, 4) == 0,
                     int'($urandom_range(0, PC_MOD - 1)),
                     $urandom_range(0, 2) == 0,
                     $urandom_range(0, 2) == 0,
                     int'($urandom_range(0, (1 << OFS_W) - 1)),
                     $urandom_range(0, 11) == 0);
        end

        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
